dwconv_kxk_pipe: RTL and testbench

Parametrised, fully pipelined depthwise K×K convolution engine for the MobileNetV2 datapath. It processes LANES channels in parallel, one window per accepted beat. Each window goes through a registered multiply stage, a registered adder tree, bias add, and a rounding requantiser with a selectable activation clamp. It sits between the line-buffer/window generator and the pointwise stage, with valid/ready backpressure on both sides.

---
 rtl/dwconv_kxk_pipe_pkg.sv | 39 +++
 rtl/dwconv_kxk_pipe_if.sv | 38 +++
 rtl/dwconv_kxk_pipe_lane.sv | 106 ++++++++++
 rtl/dwconv_kxk_pipe.sv | 85 ++++++++
 tb/tb_dwconv_kxk_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dwconv_kxk_pipe_pkg.sv
// Shared types and helpers for the depthwise KxK convolution pipeline.
// Holds the activation encoding, the per-beat control word and the tree sizing functions.
package dwconv_pkg;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_RELU6 = 2'd2
    } act_mode_e;

    localparam int SHIFT_W = 5;

    // Control that travels alongside each beat through the pipeline.
    typedef struct packed {
        logic [SHIFT_W-1:0] shift;
        logic [1:0]         act;
        logic               last;
    } beat_ctrl_t;

    // Number of registered adder-tree levels, ceil(log2(n)).
    function automatic int tree_levels(input int n);
        int l;
        l = 0;
        while ((1 << l) < n) l++;
        return l;
    endfunction

    // Live node count after `lvl` pairwise reductions of n elements.
    function automatic int level_count(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

    function automatic longint sat_clamp(input longint x, input longint lo, input longint hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/dwconv_kxk_pipe_if.sv
// Beat-level bus of the depthwise conv engine: upstream window/weights/config and
// downstream accumulator/quantised result, each with its own valid/ready pair.
interface dwconv_kxk_pipe_if #(
    parameter int K        = 3,
    parameter int LANES    = 1,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*K*K*DATA_W-1:0]   in_window;
    logic [LANES*K*K*WEIGHT_W-1:0] in_weights;
    logic [LANES*ACC_W-1:0]        in_bias;
    logic                          in_last;
    logic                          cfg_signed;
    logic [4:0]                    cfg_shift;
    logic [1:0]                    cfg_act;
    logic [OUT_W-1:0]              cfg_relu6_max;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES*ACC_W-1:0]        out_acc;
    logic [LANES*OUT_W-1:0]        out_q;
    logic                          out_last;

    modport master (
        output in_valid, in_window, in_weights, in_bias, in_last,
               cfg_signed, cfg_shift, cfg_act, cfg_relu6_max, out_ready,
        input  in_ready, out_valid, out_acc, out_q, out_last
    );

    modport slave (
        input  in_valid, in_window, in_weights, in_bias, in_last,
               cfg_signed, cfg_shift, cfg_act, cfg_relu6_max, out_ready,
        output in_ready, out_valid, out_acc, out_q, out_last
    );
endinterface

// File: rtl/dwconv_kxk_pipe_lane.sv
// One channel of the depthwise conv: registered multiply, registered adder tree,
// bias add and rounding requantiser with activation clamp.
module dwconv_lane
    import dwconv_pkg::*;
#(
    parameter int K        = 3,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    en_i,
    input  logic                    out_load_i,
    input  logic                    cfg_signed_i,
    input  logic [K*K*DATA_W-1:0]   window_i,
    input  logic [K*K*WEIGHT_W-1:0] weights_i,
    input  logic [ACC_W-1:0]        bias_i,
    input  logic [SHIFT_W-1:0]      rq_shift_i,
    input  logic [1:0]              rq_act_i,
    input  logic [OUT_W-1:0]        rq_relu6_max_i,
    output logic [ACC_W-1:0]        acc_o,
    output logic [OUT_W-1:0]        q_o
);
    localparam int N   = K * K;
    localparam int LVL = tree_levels(N);
    localparam longint Q_MAX = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint Q_MIN = -Q_MAX - 1;

    logic [ACC_W-1:0] prod_d  [N];
    logic [ACC_W-1:0] lvl_q   [LVL+1][N];
    logic [ACC_W-1:0] bias_q  [LVL+1];
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] acc_q;
    logic [OUT_W-1:0] q_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            prod_d[i] = ACC_W'(
                signed'({cfg_signed_i & window_i[i*DATA_W + DATA_W-1], window_i[i*DATA_W +: DATA_W]}) *
                signed'({cfg_signed_i & weights_i[i*WEIGHT_W + WEIGHT_W-1], weights_i[i*WEIGHT_W +: WEIGHT_W]}));
        end
    end

    // NOTE: datapath registers carry no reset; stale contents are harmless because the
    // reset valid chain gates every load into the architecturally visible output registers.
    always_ff @(posedge clock) begin
        if (en_i) begin
            for (int i = 0; i < N; i++) lvl_q[0][i] <= prod_d[i];
            bias_q[0] <= bias_i;
            for (int l = 1; l <= LVL; l++) begin
                bias_q[l] <= bias_q[l-1];
                for (int i = 0; i < N; i++) begin
                    if (i < level_count(N, l)) begin
                        if (2*i + 1 < level_count(N, l-1))
                            lvl_q[l][i] <= lvl_q[l-1][2*i] + lvl_q[l-1][2*i+1];
                        else
                            lvl_q[l][i] <= lvl_q[l-1][2*i];
                    end else begin
                        lvl_q[l][i] <= '0;
                    end
                end
            end
            sum_q <= lvl_q[LVL][0] + bias_q[LVL];
        end
    end

    logic signed [ACC_W:0] rnd_sum;
    logic signed [ACC_W:0] r;
    longint                lo, hi;
    logic [OUT_W-1:0]      q_d;

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        rnd_sum = {sum_q[ACC_W-1], sum_q};
        lo      = Q_MIN;
        hi      = Q_MAX;
        if (rq_shift_i != '0)
            rnd_sum = rnd_sum + ((ACC_W+1)'(1) << (rq_shift_i - 5'd1));
        r = rnd_sum >>> rq_shift_i;
        case (rq_act_i)
            ACT_RELU:  lo = 0;
            ACT_RELU6: begin
                lo = 0;
                hi = longint'(rq_relu6_max_i);
            end
            default:   ;
        endcase
        q_d = OUT_W'(sat_clamp(longint'(r), lo, hi));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            q_q   <= '0;
        end else if (en_i && out_load_i) begin
            acc_q <= sum_q;
            q_q   <= q_d;
        end
    end

    assign acc_o = acc_q;
    assign q_o   = q_q;

endmodule

// File: rtl/dwconv_kxk_pipe.sv
// Depthwise KxK convolution engine: LANES independent lanes sharing one valid/last/config
// shift register and a single global stall derived from output backpressure.
module dwconv_kxk_pipe
    import dwconv_pkg::*;
#(
    parameter int K        = 3,
    parameter int LANES    = 1,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 8
) (
    input logic             clock,
    input logic             reset_n,
    dwconv_kxk_pipe_if.slave bus
);
    localparam int N   = K * K;
    localparam int LVL = tree_levels(N);
    localparam int L   = LVL + 3;

    logic             en;
    logic [L-1:0]     vld_q;
    beat_ctrl_t       ctrl_q [L];
    logic [OUT_W-1:0] r6_q   [L-1];
    logic [ACC_W-1:0] lane_acc [LANES];
    logic [OUT_W-1:0] lane_q   [LANES];

    // The whole pipe advances together; a held output freezes every stage.
    assign en           = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = en;

    // NOTE: sequential state uses non-blocking assignments so each stage samples the
    // previous stage's pre-edge value and the shift register does not collapse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            for (int i = 0; i < L; i++) ctrl_q[i] <= '0;
        end else if (en) begin
            vld_q     <= {vld_q[L-2:0], bus.in_valid};
            ctrl_q[0] <= '{shift: bus.cfg_shift, act: bus.cfg_act,
                           last: bus.in_valid & bus.in_last};
            for (int i = 1; i < L; i++) ctrl_q[i] <= ctrl_q[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (en) begin
            r6_q[0] <= bus.cfg_relu6_max;
            for (int i = 1; i < L-1; i++) r6_q[i] <= r6_q[i-1];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dwconv_lane #(
            .K(K), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .ACC_W(ACC_W), .OUT_W(OUT_W)
        ) u_lane (
            .clock          (clock),
            .reset_n        (reset_n),
            .en_i           (en),
            .out_load_i     (vld_q[L-2]),
            .cfg_signed_i   (bus.cfg_signed),
            .window_i       (bus.in_window[g*N*DATA_W +: N*DATA_W]),
            .weights_i      (bus.in_weights[g*N*WEIGHT_W +: N*WEIGHT_W]),
            .bias_i         (bus.in_bias[g*ACC_W +: ACC_W]),
            .rq_shift_i     (ctrl_q[L-2].shift),
            .rq_act_i       (ctrl_q[L-2].act),
            .rq_relu6_max_i (r6_q[L-2]),
            .acc_o          (lane_acc[g]),
            .q_o            (lane_q[g])
        );
    end

    always_comb begin
        bus.out_acc = '0;
        bus.out_q   = '0;
        for (int g = 0; g < LANES; g++) begin
            bus.out_acc[g*ACC_W +: ACC_W] = lane_acc[g];
            bus.out_q[g*OUT_W +: OUT_W]   = lane_q[g];
        end
    end

    assign bus.out_valid = vld_q[L-1];
    assign bus.out_last  = ctrl_q[L-1].last;

endmodule

// File: tb/tb_dwconv_kxk_pipe.sv
// Directed bench for dwconv_kxk_pipe: a K=3 single-lane instance and a K=5 two-lane
// instance, with a scoreboard queue per instance filled at accept and drained at output.
module tb_dwconv_kxk_pipe;
    import dwconv_pkg::*;

    localparam int DW = 8, WW = 8, AW = 32, OW = 8;
    localparam int KA = 3, LA = 1, NA = 9,  LAT_A = 7;
    localparam int KB = 5, LB = 2, NB = 25, LAT_B = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    dwconv_kxk_pipe_if #(.K(KA), .LANES(LA), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW), .OUT_W(OW)) bus_a ();
    dwconv_kxk_pipe_if #(.K(KB), .LANES(LB), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW), .OUT_W(OW)) bus_b ();

    dwconv_kxk_pipe #(.K(KA), .LANES(LA), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW), .OUT_W(OW)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a.slave));
    dwconv_kxk_pipe #(.K(KB), .LANES(LB), .DATA_W(DW), .WEIGHT_W(WW), .ACC_W(AW), .OUT_W(OW)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b.slave));

    typedef struct {
        logic [63:0] acc;
        logic [15:0] q;
        logic        last;
        int          cyc;
        bit          chk_lat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   stall_at = 1000000;

    // Directed expectations; when ovr_a is clear the reference model is used instead.
    bit          ovr_a = 1'b0;
    logic [63:0] ovr_acc_a;
    logic [15:0] ovr_q_a;
    bit          lat_a = 1'b0;
    logic [63:0] ovr_acc_b;
    logic [15:0] ovr_q_b;
    bit          lat_b = 1'b0;

    bit          prev_stall_a = 1'b0;
    logic [63:0] prev_acc_a;
    logic [15:0] prev_q_a;
    logic        prev_last_a;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [NB*DW-1:0] win, input logic [NB*WW-1:0] wts,
                                  input int taps, input logic [AW-1:0] bias, input logic sgn,
                                  input logic [4:0] sh, input logic [1:0] act, input logic [OW-1:0] r6,
                                  output logic [AW-1:0] acc, output logic [OW-1:0] q);
        longint s, d, w, a, lo, hi;
        s = 0;
        for (int i = 0; i < taps; i++) begin
            d = longint'(win[i*DW +: DW]);
            w = longint'(wts[i*WW +: WW]);
            if (sgn && d[DW-1]) d = d - (longint'(1) << DW);
            if (sgn && w[WW-1]) w = w - (longint'(1) << WW);
            s = s + d * w;
        end
        s   = s + longint'(signed'(bias));
        acc = s[AW-1:0];
        a   = longint'(signed'(acc));
        if (sh != 5'd0) a = a + (longint'(1) << (sh - 5'd1));
        a = a >>> sh;
        case (act)
            2'd1:    begin lo = 0;    hi = 127; end
            2'd2:    begin lo = 0;    hi = longint'(r6); end
            default: begin lo = -128; hi = 127; end
        endcase
        if (a < lo) a = lo;
        if (a > hi) a = hi;
        q = a[OW-1:0];
    endfunction

    // One clock: entered and left at posedge+1; samples at posedge+2.
    task automatic cycle(output bit acc_a, output bit acc_b);
        exp_t e;
        logic [NB*DW-1:0] win;
        logic [NB*WW-1:0] wts;
        logic [AW-1:0]    m_acc;
        logic [OW-1:0]    m_q;
        bus_a.out_ready = !(cyc >= stall_at && cyc < stall_at + 4);
        #1;
        check("a_in_ready_rule", 64'(bus_a.in_ready), 64'(!(bus_a.out_valid && !bus_a.out_ready)));
        if (prev_stall_a) begin
            check("a_hold_valid", 64'(bus_a.out_valid), 64'd1);
            check("a_hold_acc",   64'(bus_a.out_acc),   prev_acc_a);
            check("a_hold_q",     64'(bus_a.out_q),     64'(prev_q_a));
            check("a_hold_last",  64'(bus_a.out_last),  64'(prev_last_a));
        end
        if (bus_a.out_valid && bus_a.out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_beat", 64'(bus_a.out_valid), 64'd0);
            end else begin
                e = qa.pop_front();
                check("a_out_acc",  64'(bus_a.out_acc),  e.acc);
                check("a_out_q",    64'(bus_a.out_q),    64'(e.q));
                check("a_out_last", 64'(bus_a.out_last), 64'(e.last));
                if (e.chk_lat) check("a_latency", 64'(cyc - e.cyc), 64'(LAT_A));
            end
        end
        if (bus_b.out_valid && bus_b.out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_beat", 64'(bus_b.out_valid), 64'd0);
            end else begin
                e = qb.pop_front();
                check("b_out_acc",  64'(bus_b.out_acc),  e.acc);
                check("b_out_q",    64'(bus_b.out_q),    64'(e.q));
                check("b_out_last", 64'(bus_b.out_last), 64'(e.last));
                if (e.chk_lat) check("b_latency", 64'(cyc - e.cyc), 64'(LAT_B));
            end
        end
        acc_a = bus_a.in_valid && bus_a.in_ready;
        acc_b = bus_b.in_valid && bus_b.in_ready;
        if (acc_a) begin
            if (ovr_a) begin
                e.acc = ovr_acc_a;
                e.q   = ovr_q_a;
            end else begin
                win = '0; wts = '0;
                win[NA*DW-1:0] = bus_a.in_window;
                wts[NA*WW-1:0] = bus_a.in_weights;
                model(win, wts, NA, bus_a.in_bias, bus_a.cfg_signed, bus_a.cfg_shift,
                      bus_a.cfg_act, bus_a.cfg_relu6_max, m_acc, m_q);
                e.acc = 64'(m_acc);
                e.q   = 16'(m_q);
            end
            e.last = bus_a.in_last; e.cyc = cyc; e.chk_lat = lat_a;
            qa.push_back(e);
        end
        if (acc_b) begin
            e.acc = ovr_acc_b; e.q = ovr_q_b;
            e.last = bus_b.in_last; e.cyc = cyc; e.chk_lat = lat_b;
            qb.push_back(e);
        end
        prev_stall_a = bus_a.out_valid && !bus_a.out_ready;
        prev_acc_a   = 64'(bus_a.out_acc);
        prev_q_a     = 16'(bus_a.out_q);
        prev_last_a  = bus_a.out_last;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic set_a(input logic [DW-1:0] d, input logic [WW-1:0] w, input logic [AW-1:0] bias,
                         input logic sgn, input logic [4:0] sh, input logic [1:0] act,
                         input logic [OW-1:0] r6, input logic last);
        bus_a.in_valid = 1'b1;
        for (int i = 0; i < NA; i++) begin
            bus_a.in_window[i*DW +: DW]  = d;
            bus_a.in_weights[i*WW +: WW] = w;
        end
        bus_a.in_bias = bias; bus_a.cfg_signed = sgn; bus_a.cfg_shift = sh;
        bus_a.cfg_act = act; bus_a.cfg_relu6_max = r6; bus_a.in_last = last;
    endtask

    task automatic send_a();
        bit ra, rb;
        int n;
        n = 0;
        do begin
            cycle(ra, rb);
            n++;
        end while (!ra && n < 50);
        check("a_accept_timeout", 64'(ra), 64'd1);
    endtask

    task automatic send_b();
        bit ra, rb;
        int n;
        n = 0;
        do begin
            cycle(ra, rb);
            n++;
        end while (!rb && n < 50);
        check("b_accept_timeout", 64'(rb), 64'd1);
    endtask

    task automatic drain();
        bit ra, rb;
        int n;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 60) begin
            cycle(ra, rb);
            n++;
        end
        check("drain_outstanding", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_a_valid"}, 64'(bus_a.out_valid), 64'd0);
        check({phase, "_a_acc"},   64'(bus_a.out_acc),   64'd0);
        check({phase, "_a_q"},     64'(bus_a.out_q),     64'd0);
        check({phase, "_a_last"},  64'(bus_a.out_last),  64'd0);
        check({phase, "_a_ready"}, 64'(bus_a.in_ready),  64'd1);
        check({phase, "_b_valid"}, 64'(bus_b.out_valid), 64'd0);
        check({phase, "_b_acc"},   64'(bus_b.out_acc),   64'd0);
        check({phase, "_b_ready"}, 64'(bus_b.in_ready),  64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ra, rb;
        bus_a.in_valid = 0; bus_a.in_window = '0; bus_a.in_weights = '0; bus_a.in_bias = '0;
        bus_a.in_last = 0; bus_a.cfg_signed = 0; bus_a.cfg_shift = '0; bus_a.cfg_act = '0;
        bus_a.cfg_relu6_max = '0; bus_a.out_ready = 1;
        bus_b.in_valid = 0; bus_b.in_window = '0; bus_b.in_weights = '0; bus_b.in_bias = '0;
        bus_b.in_last = 0; bus_b.cfg_signed = 0; bus_b.cfg_shift = '0; bus_b.cfg_act = '0;
        bus_b.cfg_relu6_max = '0; bus_b.out_ready = 1;

        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("por");
        reset_n = 1'b1;

        // Unsigned uniform window: 9 * 2 * 3 = 54, seven cycles from accept.
        ovr_a = 1; lat_a = 1; ovr_acc_a = 64'd54; ovr_q_a = 16'd54;
        set_a(8'd2, 8'd3, 32'd0, 1'b0, 5'd0, 2'd0, 8'd0, 1'b0);
        send_a();
        drain();
        lat_a = 0;

        // Signed -128 * -128 * 9 = 147456; >>>10 with rounding = 144.
        ovr_acc_a = 64'd147456; ovr_q_a = 16'h7F;
        set_a(8'h80, 8'h80, 32'd0, 1'b1, 5'd10, 2'd0, 8'd0, 1'b0);
        send_a();
        ovr_q_a = 16'h60;
        set_a(8'h80, 8'h80, 32'd0, 1'b1, 5'd10, 2'd2, 8'd96, 1'b0);
        send_a();
        drain();

        // Bias -3, shift 1 rounds to -1: NONE gives 0xFF, RELU gives 0.
        ovr_acc_a = 64'hFFFF_FFFD; ovr_q_a = 16'hFF;
        set_a(8'd0, 8'd5, 32'hFFFF_FFFD, 1'b1, 5'd1, 2'd0, 8'd0, 1'b0);
        send_a();
        ovr_q_a = 16'h00;
        set_a(8'd0, 8'd5, 32'hFFFF_FFFD, 1'b1, 5'd1, 2'd1, 8'd0, 1'b0);
        send_a();
        drain();

        // Ten back-to-back beats with a four-cycle output stall mid-stream.
        ovr_a = 0;
        stall_at = cyc + 9;
        for (int i = 0; i < 10; i++) begin
            set_a(8'd2, 8'd3, AW'(i), 1'b0, 5'd0, 2'd0, 8'd0, i == 9);
            send_a();
        end
        drain();
        stall_at = 1000000;

        // Per-beat shift on identical acc=40 windows: 40, 10, 40, 10, ...
        ovr_a = 1; ovr_acc_a = 64'd40;
        for (int i = 0; i < 6; i++) begin
            ovr_q_a = (i % 2 == 1) ? 16'd10 : 16'd40;
            set_a(8'd2, 8'd2, 32'd4, 1'b0, (i % 2 == 1) ? 5'd2 : 5'd0, 2'd0, 8'd0, 1'b0);
            send_a();
        end
        drain();

        // Mid-flight asynchronous reset with five beats in the pipe.
        ovr_a = 0;
        for (int i = 0; i < 5; i++) begin
            set_a(8'd1, 8'd1, AW'(100 + i), 1'b0, 5'd0, 2'd0, 8'd0, i == 4);
            send_a();
        end
        bus_a.in_valid = 1'b0;
        check("rst_inflight_count", 64'(qa.size()), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        qa.delete();
        prev_stall_a = 1'b0;
        @(posedge clock);
        #1;
        check_reset_outputs("arst_hold");
        reset_n = 1'b1;
        repeat (20) cycle(ra, rb);
        check("post_reset_queue", 64'(qa.size()), 64'd0);

        // K=5 two-lane signed: lane 0 sums +25, lane 1 sums -25, latency 8.
        lat_b = 1;
        bus_b.in_valid = 1'b1; bus_b.cfg_signed = 1'b1; bus_b.cfg_shift = '0;
        bus_b.cfg_act = 2'd0; bus_b.in_bias = '0; bus_b.in_last = 1'b0;
        for (int g = 0; g < LB; g++) begin
            for (int i = 0; i < NB; i++) begin
                bus_b.in_window[(g*NB + i)*DW +: DW]  = (g == 0) ? 8'h01 : 8'hFF;
                bus_b.in_weights[(g*NB + i)*WW +: WW] = 8'h01;
            end
        end
        ovr_acc_b = {32'hFFFF_FFE7, 32'd25}; ovr_q_b = {8'hE7, 8'd25};
        send_b();
        bus_b.cfg_act = 2'd1; bus_b.in_last = 1'b1;
        ovr_q_b = {8'h00, 8'd25};
        send_b();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
